iobus_port_bank: RTL and testbench

IOBUS_PORT_BANK -- requirements
Module: iobus_port_bank

---
 rtl/iobus_port_bank.sv | 188 ++++++++++++++++++
 tb/tb_iobus_port_bank.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iobus_port_bank.sv
// ---------------------------------------------------------------------------
// iobus_port_bank
//
// Memory-mapped bank of input and output ports for an MCU IO bus.
// - N_IN external input channels. Each one is synchronised through two flops
//   and can be read back from IN[i].
// - N_OUT registered external output channels, written through OUT[i].
// - An optional change-detect interrupt block with PEND (write-1-to-clear)
//   and ENA registers.
//
// Register map (word addresses; iobus_addr[1:0] is ignored):
//   BASE + 0x00 + 4*i : IN[i]   read-only, synchronised ext_in channel i
//   BASE + 0x40 + 4*i : OUT[i]  read/write, drives ext_out channel i
//   BASE + 0x80       : PEND    change-pending flags, write 1 to clear
//   BASE + 0x84       : ENA     interrupt enable per input channel
// Unmapped addresses and out-of-range indices read 0. Writes to them are ignored.
//
// Configuration macro: IOBUS_PORT_INTR_EN
//   defined   -> PEND, ENA, change detection and intr are present
//   undefined -> no interrupt storage, intr tied 0, PEND/ENA read 0
//
// Ports:
//   clk        in   clock, rising edge
//   RST        in   asynchronous active-low reset
//   iobus_addr in   [31:0] MCU IO address
//   iobus_out  in   [31:0] MCU write data
//   iobus_wr   in   write strobe, one cycle per store
//   iobus_in   out  [31:0] combinational read data
//   ext_in     in   [N_IN*DATA_W-1:0] asynchronous external inputs
//   ext_out    out  [N_OUT*DATA_W-1:0] registered external outputs
//   intr       out  registered level interrupt request
// ---------------------------------------------------------------------------
module iobus_port_bank #(
    parameter int          DATA_W    = 32,
    parameter int          N_IN      = 4,
    parameter int          N_OUT     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h11000000
) (
    input  logic                      clk,
    input  logic                      RST,
    input  logic [31:0]               iobus_addr,
    input  logic [31:0]               iobus_out,
    input  logic                      iobus_wr,
    output logic [31:0]               iobus_in,
    input  logic [N_IN*DATA_W-1:0]    ext_in,
    output logic [N_OUT*DATA_W-1:0]   ext_out,
    output logic                      intr
);

    localparam int IW = N_IN * DATA_W;
    localparam int OW = N_OUT * DATA_W;

    // Word offset from the base. An address below BASE wraps to a huge
    // offset, so every region check below rejects it.
    logic [29:0]       rel_s;
    logic [3:0]        idx_s;
    logic              sel_in_s;
    logic              sel_out_s;
    logic              sel_pend_s;
    logic              sel_ena_s;

    logic [IW-1:0]     sync1_r;
    logic [IW-1:0]     sync2_r;
    logic [OW-1:0]     out_r;

    logic [DATA_W-1:0] in_word_s;
    logic [DATA_W-1:0] out_word_s;
    logic [31:0]       pend_rd_s;
    logic [31:0]       ena_rd_s;
    logic [31:0]       rd_data_s;

    logic              unused_s;

    assign rel_s      = iobus_addr[31:2] - BASE_ADDR[31:2];
    assign idx_s      = rel_s[3:0];
    assign sel_in_s   = (rel_s[29:4] == 26'd0);
    assign sel_out_s  = (rel_s[29:4] == 26'd1);
    assign sel_pend_s = (rel_s == 30'd32);
    assign sel_ena_s  = (rel_s == 30'd33);

    // Byte lane bits and write-data bits above the channel width are not used.
    assign unused_s = ^{iobus_addr[1:0], iobus_out};

    // Two-flop synchroniser for every external input channel.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            sync1_r <= {IW{1'b0}};
            sync2_r <= {IW{1'b0}};
        end else begin
            sync1_r <= ext_in;
            sync2_r <= sync1_r;
        end
    end

    // Output port registers, loaded by stores to OUT[i].
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            out_r <= {OW{1'b0}};
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (iobus_wr && sel_out_s && (idx_s == 4'(i))) begin
                    out_r[i*DATA_W +: DATA_W] <= iobus_out[DATA_W-1:0];
                end
            end
        end
    end

    assign ext_out = out_r;

`ifdef IOBUS_PORT_INTR_EN
    logic [IW-1:0]   prev_r;
    logic [N_IN-1:0] pend_r;
    logic [N_IN-1:0] ena_r;
    logic            intr_r;
    logic [N_IN-1:0] chg_s;
    logic [N_IN-1:0] clr_s;

    // A channel has changed when its synchronised value differs from the
    // value it had one cycle earlier.
    always_comb begin
        chg_s = {N_IN{1'b0}};
        for (int i = 0; i < N_IN; i++) begin
            chg_s[i] = (sync2_r[i*DATA_W +: DATA_W] != prev_r[i*DATA_W +: DATA_W]);
        end
    end

    assign clr_s = (iobus_wr && sel_pend_s) ? iobus_out[N_IN-1:0] : {N_IN{1'b0}};

    // Change history, pending flags (a set wins over a clear at the same edge),
    // enable mask, and the interrupt request registered from the pending flags.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            prev_r <= {IW{1'b0}};
            pend_r <= {N_IN{1'b0}};
            ena_r  <= {N_IN{1'b0}};
            intr_r <= 1'b0;
        end else begin
            prev_r <= sync2_r;
            pend_r <= (pend_r & ~clr_s) | chg_s;
            if (iobus_wr && sel_ena_s) begin
                ena_r <= iobus_out[N_IN-1:0];
            end
            intr_r <= |(pend_r & ena_r);
        end
    end

    assign pend_rd_s = 32'(pend_r);
    assign ena_rd_s  = 32'(ena_r);
    assign intr      = intr_r;
`else
    assign pend_rd_s = 32'd0;
    assign ena_rd_s  = 32'd0;
    assign intr      = 1'b0;
`endif

    // One-hot OR mux that selects the addressed input and output channels.
    always_comb begin
        in_word_s  = {DATA_W{1'b0}};
        out_word_s = {DATA_W{1'b0}};
        for (int i = 0; i < N_IN; i++) begin
            in_word_s = in_word_s |
                ((idx_s == 4'(i)) ? sync2_r[i*DATA_W +: DATA_W] : {DATA_W{1'b0}});
        end
        for (int j = 0; j < N_OUT; j++) begin
            out_word_s = out_word_s |
                ((idx_s == 4'(j)) ? out_r[j*DATA_W +: DATA_W] : {DATA_W{1'b0}});
        end
    end

    // Read data mux. Indices with no channel fall through the OR mux as 0.
    always_comb begin
        rd_data_s = 32'd0;
        if (sel_in_s) begin
            rd_data_s = 32'(in_word_s);
        end else if (sel_out_s) begin
            rd_data_s = 32'(out_word_s);
        end else if (sel_pend_s) begin
            rd_data_s = pend_rd_s;
        end else if (sel_ena_s) begin
            rd_data_s = ena_rd_s;
        end else begin
            rd_data_s = 32'd0;
        end
    end

    assign iobus_in = rd_data_s;

endmodule

// File: tb/tb_iobus_port_bank.sv
module tb_iobus_port_bank;

    localparam int          DW   = 16;
    localparam int          NI   = 4;
    localparam int          NO   = 4;
    localparam logic [31:0] BASE = 32'h11000000;

    logic              clk = 1'b0;
    logic              RST = 1'b1;
    logic [31:0]       iobus_addr = 32'd0;
    logic [31:0]       iobus_out  = 32'd0;
    logic              iobus_wr   = 1'b0;
    logic [31:0]       iobus_in;
    logic [NI*DW-1:0]  ext_in = '0;
    logic [NO*DW-1:0]  ext_out;
    logic              intr;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    iobus_port_bank #(
        .DATA_W(DW), .N_IN(NI), .N_OUT(NO), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .RST(RST), .iobus_addr(iobus_addr), .iobus_out(iobus_out),
        .iobus_wr(iobus_wr), .iobus_in(iobus_in), .ext_in(ext_in),
        .ext_out(ext_out), .intr(intr)
    );

    // ---------------- behavioural model ----------------
    // h0/h1/h2: ext_in as sampled at the last three rising edges.
    // A read of IN[i] returns the sample from the previous edge (h1).
    // A pending bit sets when the samples from two and three edges back differ.
    logic [DW-1:0] h0 [NI];
    logic [DW-1:0] h1 [NI];
    logic [DW-1:0] h2 [NI];
    logic [DW-1:0] m_out [NO];
    logic [NI-1:0] m_pend;
    logic [NI-1:0] m_ena;
    logic          m_intr;

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off >= 32'h100) return -1;
        return int'(off >> 2);
    endfunction

    function automatic logic [NI-1:0] change_mask();
        logic [NI-1:0] m;
        for (int i = 0; i < NI; i++) m[i] = (h1[i] != h2[i]);
        return m;
    endfunction

    function automatic logic [NI-1:0] clear_mask();
        if (iobus_wr && word_of(iobus_addr) == 32) return iobus_out[NI-1:0];
        return '0;
    endfunction

    always @(posedge clk or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NI; i++) begin
                h0[i] <= '0; h1[i] <= '0; h2[i] <= '0;
            end
            for (int i = 0; i < NO; i++) m_out[i] <= '0;
            m_pend <= '0;
            m_ena  <= '0;
            m_intr <= 1'b0;
        end else begin
            for (int i = 0; i < NI; i++) begin
                h0[i] <= ext_in[i*DW +: DW];
                h1[i] <= h0[i];
                h2[i] <= h1[i];
            end
            if (iobus_wr && word_of(iobus_addr) >= 16 && word_of(iobus_addr) < 16 + NO)
                m_out[word_of(iobus_addr) - 16] <= iobus_out[DW-1:0];
`ifdef IOBUS_PORT_INTR_EN
            m_pend <= (m_pend & ~clear_mask()) | change_mask();
            if (iobus_wr && word_of(iobus_addr) == 33) m_ena <= iobus_out[NI-1:0];
            m_intr <= |(m_pend & m_ena);
`endif
        end
    end

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        int w;
        w = word_of(a);
        if (w >= 0 && w < NI) return 32'(h1[w]);
        if (w >= 16 && w < 16 + NO) return 32'(m_out[w - 16]);
`ifdef IOBUS_PORT_INTR_EN
        if (w == 32) return 32'(m_pend);
        if (w == 33) return 32'(m_ena);
`endif
        return 32'd0;
    endfunction

    function automatic logic [NO*DW-1:0] exp_ext_out();
        logic [NO*DW-1:0] v;
        for (int i = 0; i < NO; i++) v[i*DW +: DW] = m_out[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("ext_out", 64'(ext_out), 64'(exp_ext_out()));
            chk("iobus_in", 64'(iobus_in), 64'(exp_read(iobus_addr)));
            chk("intr", 64'(intr), 64'(m_intr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        iobus_addr = a; iobus_out = d; iobus_wr = 1'b1;
        tick();
        iobus_wr = 1'b0;
    endtask

    task automatic rd_chk(input string n, input logic [31:0] a, input logic [31:0] e);
        iobus_addr = a;
        #1;
        chk(n, 64'(iobus_in), 64'(e));
    endtask

    task automatic set_ch(input int c, input logic [DW-1:0] v);
        ext_in[c*DW +: DW] = v;
    endtask

    function automatic logic [31:0] rand_addr();
        int w;
        case ($urandom_range(0, 7))
            0:       w = int'($urandom_range(0, 15));
            1, 2:    w = 16 + int'($urandom_range(0, 7));
            3:       w = 32;
            4:       w = 33;
            5:       w = 34 + int'($urandom_range(0, 30));
            6:       return $urandom;
            default: w = int'($urandom_range(0, 3));
        endcase
        return BASE + 32'(4 * w) + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        // Reset held for two cycles with ext_in nonzero.
        set_ch(0, 16'h1234);
        set_ch(3, 16'h00A5);
        #1 RST = 1'b0;
        check_en = 1'b1;
        tick(); tick();
        chk("rst_ext_out", 64'(ext_out), 64'd0);
        chk("rst_intr", 64'(intr), 64'd0);
        rd_chk("rst_in0", BASE, 32'd0);
        rd_chk("rst_out1", BASE + 32'h44, 32'd0);
        rd_chk("rst_pend", BASE + 32'h80, 32'd0);
        RST = 1'b1;
        iobus_addr = BASE;
        tick();
        rd_chk("in0_one_edge", BASE, 32'd0);
        tick();
        rd_chk("in0_two_edges", BASE, 32'h00001234);
        rd_chk("in3_two_edges", BASE + 32'hC, 32'h000000A5);

        // Output write.
        wr(BASE + 32'h44, 32'h0000FEED);
        chk("out1_ext", 64'(ext_out[2*DW-1:DW]), 64'h000000000000FEED);
        rd_chk("out1_read", BASE + 32'h44, 32'h0000FEED);

        // Interrupt on a channel 0 change.
        wr(BASE + 32'h84, 32'h1);
        set_ch(0, 16'h0);
        tick(); tick(); tick(); tick();
        wr(BASE + 32'h80, 32'hF);
        set_ch(0, 16'h5);
        tick(); tick();
`ifdef IOBUS_PORT_INTR_EN
        rd_chk("pend_k1", BASE + 32'h80, 32'h0);
`endif
        tick();
`ifdef IOBUS_PORT_INTR_EN
        rd_chk("pend_k2", BASE + 32'h80, 32'h1);
        chk("intr_k2", 64'(intr), 64'd0);
`endif
        tick();
`ifdef IOBUS_PORT_INTR_EN
        chk("intr_k3", 64'(intr), 64'd1);
`endif
        wr(BASE + 32'h80, 32'h1);
        rd_chk("pend_cleared", BASE + 32'h80, 32'h0);
        tick();
        chk("intr_dropped", 64'(intr), 64'd0);

        // Set and clear of PEND[0] at the same edge.
        set_ch(0, 16'h6);
        tick(); tick(); tick(); tick();
        set_ch(0, 16'h7);
        tick(); tick();
        wr(BASE + 32'h80, 32'h1);
`ifdef IOBUS_PORT_INTR_EN
        rd_chk("collide_pend", BASE + 32'h80, 32'h1);
        chk("collide_intr", 64'(intr), 64'd1);
        tick();
        chk("collide_intr_next", 64'(intr), 64'd1);
`else
        tick();
`endif

        // Masking and decode.
        wr(BASE + 32'h84, 32'h0);
        wr(BASE + 32'h80, 32'hF);
        set_ch(2, 16'hABCD);
        tick(); tick(); tick(); tick();
`ifdef IOBUS_PORT_INTR_EN
        rd_chk("mask_pend", BASE + 32'h80, 32'h4);
`else
        rd_chk("pend_absent", BASE + 32'h80, 32'h0);
`endif
        chk("mask_intr", 64'(intr), 64'd0);
        rd_chk("in15_empty", BASE + 32'h3C, 32'd0);
        rd_chk("in2_read", BASE + 32'h8, 32'h0000ABCD);
        wr(BASE, 32'hFFFFFFFF);
        wr(BASE + 32'h50, 32'hFFFFFFFF);
        chk("ro_write", 64'(ext_out), 64'h00000000FEED0000);
        rd_chk("out1_after", BASE + 32'h44, 32'h0000FEED);

        // Randomised phase; the compare process checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            iobus_addr = rand_addr();
            iobus_out  = $urandom;
            iobus_wr   = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0)
                set_ch(int'($urandom_range(0, NI - 1)), DW'($urandom));
            if (n == 700 || n == 2100) wr(BASE + 32'h84, 32'(4'hF));
            if (n == 1500) RST = 1'b0;
            if (n == 1502) RST = 1'b1;
            tick();
        end

        iobus_wr = 1'b0;
        tick();
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
